// File: rtl/aes_pkg.sv
// Shared types and constants for the AES decrypt scheduler: FSM encoding,
// block width and the FIPS-197 AES-128 reference vector.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

  localparam logic [BLOCK_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BLOCK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [BLOCK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_dec_sched_if.sv
// Requester, core-sequencing and result buses of the AES decrypt scheduler.
// slave is the scheduler's view, master is the surrounding system's view.
interface aes_dec_sched_if;
  import aes_pkg::*;

  logic               req0_valid;
  logic [BLOCK_W-1:0] req0_data;
  logic               req0_ready;
  logic               req1_valid;
  logic [BLOCK_W-1:0] req1_data;
  logic               req1_ready;
  logic [BLOCK_W-1:0] core_data_in;
  logic               core_rst;
  logic               core_en;
  logic               core_done;
  logic [BLOCK_W-1:0] core_data_out;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_id;
  logic               out_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  core_done, core_data_out, out_ready,
    output req0_ready, req1_ready, core_data_in, core_rst, core_en,
    output out_valid, out_data, out_id, out_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output core_done, core_data_out, out_ready,
    input  req0_ready, req1_ready, core_data_in, core_rst, core_en,
    input  out_valid, out_data, out_id, out_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. ptr_q names the preferred requester and flips to
// the opposite of whoever was just granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_id_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    gnt_o    = 2'b00;
    if (|req_i) gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    ptr_d    = (accept_i && |req_i) ? ~gnt_id_o : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_dec_sched.sv
// Arbitrates two requesters onto one multi-cycle AES inverse-cipher core,
// sequencing restart/enable per job with a watchdog on hung jobs.
module aes_dec_sched
  import aes_pkg::*;
#(
  parameter int Nr         = 10,
  parameter int MAX_CYCLES = 64,
  parameter int CW         = 7
) (
  input  logic           clk,
  input  logic           rst,
  aes_dec_sched_if.slave bus
);

  // A healthy core needs 4*Nr+1 enabled cycles; never let the watchdog cut that short.
  localparam int            CORE_LAT = 4 * Nr + 1;
  localparam int            WD_LIMIT = (MAX_CYCLES > CORE_LAT) ? MAX_CYCLES : CORE_LAT + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WD_LIMIT - 1);

  state_e             state_q;
  logic [BLOCK_W-1:0] core_data_q;
  logic [BLOCK_W-1:0] out_data_q;
  logic               core_en_q;
  logic               out_valid_q;
  logic               out_id_q;
  logic               out_err_q;
  logic [CW-1:0]      cnt_q;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       idle;
  logic       accept;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && (bus.req0_valid || bus.req1_valid);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({bus.req1_valid, bus.req0_valid}),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign bus.req0_ready   = idle && gnt[0];
  assign bus.req1_ready   = idle && gnt[1];
  assign bus.core_rst     = rst || (state_q == ST_LOAD);
  assign bus.core_en      = core_en_q;
  assign bus.core_data_in = core_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_id       = out_id_q;
  assign bus.out_err      = out_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_data_q <= '0;
      core_en_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            core_data_q <= gnt_id ? bus.req1_data : bus.req0_data;
            out_id_q    <= gnt_id;
            state_q     <= ST_LOAD;
          end
        end
        // core_rst is high for this one cycle, flushing any stale done
        ST_LOAD: begin
          cnt_q     <= '0;
          core_en_q <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.core_done) begin
            out_data_q  <= bus.core_data_out;
            out_err_q   <= 1'b0;
            core_en_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DELIVER;
          end else if (cnt_q == CNT_LAST) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            core_en_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
